// File: rtl/remote_access_pkg.sv
// remote_access_pkg
// Shared types for the remote-access bridge: command kinds, the decoded
// command record carried through launch/buffer/engine, FSM states and the
// sticky error bit positions.
package remote_access_pkg;

  typedef enum logic [2:0] {
    CMD_WR_W,
    CMD_WR_H,
    CMD_WR_B,
    CMD_RD_W,
    CMD_RD_N,
    CMD_ILLEGAL
  } cmd_e;

  // addr is already word aligned; count is the number of bus words still to
  // issue (1 for everything except bursts).
  typedef struct packed {
    cmd_e        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [15:0] count;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } state_e;

  localparam int unsigned ERR_ILLEGAL  = 0;
  localparam int unsigned ERR_MISALIGN = 1;
  localparam int unsigned ERR_OVERRUN  = 2;
  localparam int unsigned ERR_TIMEOUT  = 3;

  function automatic logic is_read(cmd_e t);
    return (t == CMD_RD_W) || (t == CMD_RD_N);
  endfunction

endpackage

// File: rtl/remote_access_decode.sv
// remote_access_decode
// Combinational command decoder.
//   wr_word_i..rd_numwords_i : command flags (exactly one must be set)
//   addr_i, data_i           : raw command address / data
//   cmd_o                    : decoded command (aligned addr, be, wdata, count)
//   illegal_o                : flag count != 1
//   misaligned_o             : address alignment violated for the command
module remote_access_decode
  import remote_access_pkg::*;
#(
  parameter int unsigned MAX_BURST = 256
) (
  input  logic        wr_word_i,
  input  logic        wr_halfword_i,
  input  logic        wr_byte_i,
  input  logic        rd_word_i,
  input  logic        rd_numwords_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output cmd_t        cmd_o,
  output logic        illegal_o,
  output logic        misaligned_o
);

  logic [2:0] nflags;

  always_comb begin
    nflags = {2'b0, wr_word_i} + {2'b0, wr_halfword_i} + {2'b0, wr_byte_i}
           + {2'b0, rd_word_i} + {2'b0, rd_numwords_i};
    illegal_o    = (nflags != 3'd1);
    misaligned_o = 1'b0;
    cmd_o        = '0;
    cmd_o.typ    = CMD_ILLEGAL;
    cmd_o.addr   = {addr_i[31:2], 2'b00};
    cmd_o.count  = 16'd1;

    if (!illegal_o) begin
      if (wr_word_i) begin
        cmd_o.typ    = CMD_WR_W;
        cmd_o.be     = 4'b1111;
        cmd_o.wdata  = data_i;
        misaligned_o = (addr_i[1:0] != 2'b00);
      end else if (wr_halfword_i) begin
        cmd_o.typ    = CMD_WR_H;
        cmd_o.be     = addr_i[1] ? 4'b1100 : 4'b0011;
        cmd_o.wdata  = {2{data_i[15:0]}};
        misaligned_o = addr_i[0];
      end else if (wr_byte_i) begin
        cmd_o.typ    = CMD_WR_B;
        cmd_o.be     = 4'b0001 << addr_i[1:0];
        cmd_o.wdata  = {4{data_i[7:0]}};
      end else if (rd_word_i) begin
        cmd_o.typ    = CMD_RD_W;
        cmd_o.be     = 4'b1111;
        misaligned_o = (addr_i[1:0] != 2'b00);
      end else begin
        cmd_o.typ    = CMD_RD_N;
        cmd_o.be     = 4'b1111;
        cmd_o.count  = ({16'b0, data_i[15:0]} > 32'(MAX_BURST)) ? 16'(MAX_BURST)
                                                                : data_i[15:0];
        misaligned_o = (addr_i[1:0] != 2'b00);
      end
    end
  end

endmodule

// File: rtl/remote_access_bridge.sv
// remote_access_bridge
// Turns remote-access commands into PULP req/gnt/rvalid bus transactions.
//   clk, rst            : clock, async active-high reset
//   cmd_*, cmd_valid    : command flags, address, data and one-cycle strobe
//   rsp_data, rsp_valid : read data response (one-cycle strobe)
//   data_*              : data bus master port, one transaction outstanding
//   err_clr, err_status : sticky errors {timeout, overrun, misaligned, illegal}
//   busy                : engine active or a command is waiting
// The remote side cannot be stalled, so there is a launch slot (command
// accepted while idle, started next cycle) plus a one-entry pending buffer.
module remote_access_bridge
  import remote_access_pkg::*;
#(
  parameter int unsigned MAX_BURST      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_wr_word,
  input  logic        cmd_wr_halfword,
  input  logic        cmd_wr_byte,
  input  logic        cmd_rd_word,
  input  logic        cmd_rd_numwords,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        err_clr,
  output logic [3:0]  err_status,
  output logic        busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  cmd_t   dec_cmd;
  logic   dec_illegal, dec_misaligned;

  state_e            state_q, state_d;
  cmd_t              cur_q, cur_d;
  logic              start_q, start_d;
  cmd_t              buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [3:0]        err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              tmr_hit;

  remote_access_decode #(.MAX_BURST(MAX_BURST)) u_decode (
    .wr_word_i     (cmd_wr_word),
    .wr_halfword_i (cmd_wr_halfword),
    .wr_byte_i     (cmd_wr_byte),
    .rd_word_i     (cmd_rd_word),
    .rd_numwords_i (cmd_rd_numwords),
    .addr_i        (cmd_addr),
    .data_i        (cmd_data),
    .cmd_o         (dec_cmd),
    .illegal_o     (dec_illegal),
    .misaligned_o  (dec_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      start_q     <= 1'b0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      tmr_q       <= '0;
      err_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      start_q     <= start_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    start_d     = start_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    tmr_d       = '0;            // cleared on every state entry
    err_d       = err_clr ? 4'b0 : err_q;  // new errors below override the clear
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_hit     = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          state_d = REQ;
        end else if (buf_vld_q) begin
          cur_d     = buf_q;
          buf_vld_d = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          state_d = WAIT_RSP;
        end else if (tmr_hit) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = IDLE;
          if (is_read(cur_q.typ)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ERR_DATA;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_RSP: begin
        if (data_rvalid_i) begin
          if (is_read(cur_q.typ)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_rdata_i;
          end
          if (cur_q.count > 16'd1) begin
            cur_d.addr  = cur_q.addr + 32'd4;
            cur_d.count = cur_q.count - 16'd1;
            state_d     = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (tmr_hit) begin
          // abort drops whatever is left of a burst
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = IDLE;
          if (is_read(cur_q.typ)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ERR_DATA;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance. The engine only touches cur/buf above when start_q or
    // buf_vld_q is set, which excludes the matching branches here.
    if (cmd_valid) begin
      if (dec_illegal) begin
        err_d[ERR_ILLEGAL] = 1'b1;
      end else if (dec_misaligned) begin
        err_d[ERR_MISALIGN] = 1'b1;
      end else if (dec_cmd.count != 16'd0) begin  // zero-length burst is a no-op
        if (state_q == IDLE && !start_q && !buf_vld_q) begin
          cur_d   = dec_cmd;
          start_d = 1'b1;
        end else if (!buf_vld_q) begin
          buf_d     = dec_cmd;
          buf_vld_d = 1'b1;
        end else begin
          err_d[ERR_OVERRUN] = 1'b1;
        end
      end
    end
  end

  // Bus outputs are qualified by REQ so they read as zero when idle and
  // drop together with the request on reset.
  assign data_req_o   = (state_q == REQ);
  assign data_we_o    = data_req_o && !is_read(cur_q.typ);
  assign data_be_o    = data_req_o ? cur_q.be    : 4'b0;
  assign data_addr_o  = data_req_o ? cur_q.addr  : 32'b0;
  assign data_wdata_o = data_req_o ? cur_q.wdata : 32'b0;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_status = err_q;
  assign busy       = (state_q != IDLE) || start_q || buf_vld_q;

endmodule

// File: tb/tb_remote_access_bridge.sv
// Directed bench for remote_access_bridge (MAX_BURST=4, TIMEOUT_CYCLES=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_remote_access_bridge;

  localparam logic [4:0] F_WW = 5'b10000;
  localparam logic [4:0] F_WH = 5'b01000;
  localparam logic [4:0] F_WB = 5'b00100;
  localparam logic [4:0] F_RW = 5'b00010;
  localparam logic [4:0] F_RN = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_wr_word, cmd_wr_halfword, cmd_wr_byte, cmd_rd_word, cmd_rd_numwords;
  logic [31:0] cmd_addr, cmd_data;
  logic        cmd_valid;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        err_clr;
  logic [3:0]  err_status;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  remote_access_bridge #(
    .MAX_BURST      (4),
    .TIMEOUT_CYCLES (16),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_wr_word     (cmd_wr_word),
    .cmd_wr_halfword (cmd_wr_halfword),
    .cmd_wr_byte     (cmd_wr_byte),
    .cmd_rd_word     (cmd_rd_word),
    .cmd_rd_numwords (cmd_rd_numwords),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .rsp_data        (rsp_data),
    .rsp_valid       (rsp_valid),
    .data_req_o      (data_req_o),
    .data_gnt_i      (data_gnt_i),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_rvalid_i   (data_rvalid_i),
    .data_rdata_i    (data_rdata_i),
    .err_clr         (err_clr),
    .err_status      (err_status),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d);
    {cmd_wr_word, cmd_wr_halfword, cmd_wr_byte, cmd_rd_word, cmd_rd_numwords} = f;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    {cmd_wr_word, cmd_wr_halfword, cmd_wr_byte, cmd_rd_word, cmd_rd_numwords} = 5'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!data_req_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(data_req_o), 32'd1);
  endtask

  // Check the request, grant it, answer after lat idle cycles, check response.
  task automatic serve(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic ewe, input logic [31:0] ewd, input logic [31:0] rd,
                       input int lat);
    wait_req(tag);
    chk({tag, "_addr"}, data_addr_o, ea);
    chk({tag, "_be"}, 32'(data_be_o), 32'(ebe));
    chk({tag, "_we"}, 32'(data_we_o), 32'(ewe));
    if (ewe) chk({tag, "_wdata"}, data_wdata_o, ewd);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    repeat (lat) @(negedge clk);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    if (!ewe) begin
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_data"}, rsp_data, rd);
    end else begin
      chk({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    {cmd_wr_word, cmd_wr_halfword, cmd_wr_byte, cmd_rd_word, cmd_rd_numwords} = 5'b0;
    cmd_addr = '0; cmd_data = '0; cmd_valid = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_req", 32'(data_req_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", 32'(err_status), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_be", 32'(data_be_o), 0);
    rst = 1'b0;
    tick();

    // byte write to lane 3
    send(F_WB, 32'h1000_0003, 32'h0000_00A5);
    serve("wrb", 32'h1000_0000, 4'b1000, 1'b1, 32'hA5A5_A5A5, 32'h0, 1);
    chk("wrb_idle", 32'(busy), 0);

    // halfword write, upper half
    send(F_WH, 32'h0000_0502, 32'h1234_BEEF);
    serve("wrh", 32'h0000_0500, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0, 0);

    // single read, cycle-exact: rsp_valid 4 cycles after cmd_valid
    send(F_RW, 32'h0000_0040, 32'h0);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_c1_req", 32'(data_req_o), 0);
    tick();
    chk("lat_c2_req", 32'(data_req_o), 1);
    chk("lat_addr", data_addr_o, 32'h0000_0040);
    chk("lat_we", 32'(data_we_o), 0);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("lat_c3_req", 32'(data_req_o), 0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    tick();
    data_rvalid_i = 1'b0;
    chk("lat_rsp_valid", 32'(rsp_valid), 1);
    chk("lat_rsp_data", rsp_data, 32'h1234_5678);
    tick();
    chk("lat_rsp_pulse", 32'(rsp_valid), 0);
    chk("lat_idle", 32'(busy), 0);

    // burst of 3; upper data bits must be ignored
    send(F_RN, 32'h2000_0000, 32'hABCD_0003);
    serve("bst0", 32'h2000_0000, 4'b1111, 1'b0, 32'h0, 32'h11, 0);
    serve("bst1", 32'h2000_0004, 4'b1111, 1'b0, 32'h0, 32'h22, 2);
    serve("bst2", 32'h2000_0008, 4'b1111, 1'b0, 32'h0, 32'h33, 0);
    chk("bst_idle", 32'(busy), 0);

    // count 9 clamps to MAX_BURST=4
    send(F_RN, 32'h3000_0000, 32'h0000_0009);
    serve("clp0", 32'h3000_0000, 4'b1111, 1'b0, 32'h0, 32'h1, 0);
    serve("clp1", 32'h3000_0004, 4'b1111, 1'b0, 32'h0, 32'h2, 0);
    serve("clp2", 32'h3000_0008, 4'b1111, 1'b0, 32'h0, 32'h3, 0);
    serve("clp3", 32'h3000_000C, 4'b1111, 1'b0, 32'h0, 32'h4, 0);
    repeat (3) tick();
    chk("clp_no_more_req", 32'(data_req_o), 0);
    chk("clp_idle", 32'(busy), 0);

    // address wraps past 2^32
    send(F_RN, 32'hFFFF_FFFC, 32'h2);
    serve("wrap0", 32'hFFFF_FFFC, 4'b1111, 1'b0, 32'h0, 32'hA0, 0);
    serve("wrap1", 32'h0000_0000, 4'b1111, 1'b0, 32'h0, 32'hA1, 0);

    // zero-length burst: nothing happens, no error
    send(F_RN, 32'h0000_1000, 32'h0);
    tick();
    chk("zero_busy", 32'(busy), 0);
    chk("zero_req", 32'(data_req_o), 0);
    chk("zero_err", 32'(err_status), 0);

    // three back-to-back commands: launch, buffer, overrun
    send(F_RW, 32'h0000_0100, 32'h0);
    send(F_WW, 32'h0000_0200, 32'hCAFE_F00D);
    send(F_WW, 32'h0000_0300, 32'h5555_5555);
    chk("ovr_err", 32'(err_status), 32'h4);
    serve("ovr_rd", 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'h77, 5);
    serve("ovr_wr", 32'h0000_0200, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0, 0);
    repeat (4) tick();
    chk("ovr_third_dropped", 32'(data_req_o), 0);
    chk("ovr_idle", 32'(busy), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovr_clr", 32'(err_status), 0);

    // misaligned halfword + two flags set
    send(F_WH, 32'h0000_0001, 32'h0);
    send(F_WW | F_RW, 32'h0000_0000, 32'h0);
    chk("bad_err", 32'(err_status), 32'h3);
    chk("bad_req", 32'(data_req_o), 0);
    chk("bad_busy", 32'(busy), 0);
    err_clr = 1'b1;
    send(F_WB | F_RN, 32'h0, 32'h0);   // new error wins over clear
    err_clr = 1'b0;
    chk("clr_vs_new", 32'(err_status), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("bad_clr", 32'(err_status), 0);

    // grant never comes: abort after 16 REQ cycles
    send(F_RW, 32'h0000_0080, 32'h0);
    repeat (16) tick();
    chk("to_req_last", 32'(data_req_o), 1);
    tick();
    chk("to_req_drop", 32'(data_req_o), 0);
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("to_err", 32'(err_status), 32'h8);
    chk("to_idle", 32'(busy), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // rvalid never comes in a burst: one error response, rest skipped
    send(F_RN, 32'h5000_0000, 32'h3);
    wait_req("wto");
    data_gnt_i = 1'b1; tick(); data_gnt_i = 1'b0;
    begin
      int n = 0;
      while (!rsp_valid && n < 40) begin tick(); n++; end
    end
    chk("wto_rsp_valid", 32'(rsp_valid), 1);
    chk("wto_rsp_data", rsp_data, 32'hDEAD_BEEF);
    repeat (4) tick();
    chk("wto_no_req", 32'(data_req_o), 0);
    chk("wto_idle", 32'(busy), 0);
    chk("wto_err", 32'(err_status), 32'h8);

    // reset while requesting drops req at once
    send(F_RW, 32'h0000_0700, 32'h0);
    wait_req("rreq");
    rst = 1'b1;
    #1;
    chk("rreq_drop", 32'(data_req_o), 0);
    chk("rreq_err", 32'(err_status), 0);
    tick();
    rst = 1'b0;
    tick();

    // reset in WAIT_RSP of a burst; late rvalid ignored
    send(F_RN, 32'h6000_0000, 32'h3);
    wait_req("rwt");
    data_gnt_i = 1'b1; tick(); data_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rwt_req", 32'(data_req_o), 0);
    chk("rwt_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h99;
    tick();
    data_rvalid_i = 1'b0;
    chk("rwt_late_rsp", 32'(rsp_valid), 0);
    repeat (3) tick();
    chk("rwt_late_req", 32'(data_req_o), 0);
    chk("rwt_late_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
